// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and steps each instruction through
// FETCH -> DECODE -> EXEC -> WB. It drives the external PC ALU (pc, src2 and
// one of branchEN/jumpEN/jalEN), commits pcOut back into the PC and requests
// the link-register write for JAL.
//
// Optional feature: define PC_SEQ_BRANCH_STATS_EN to add the saturating
// taken_count / nottaken_count output ports.
//
// Fetch handshake: imem_req is high for every cycle spent in FETCH. An
// instruction is accepted on the rising edge where imem_req and instr_valid
// are both high and stall is low. instr_valid outside FETCH is ignored.
//
// Timing per instruction: the flow enable and src2 are registered on the
// DECODE->EXEC edge and are visible for the whole EXEC cycle. The PC ALU
// result is captured on the EXEC->WB edge, so pc and the link write
// (link_we/link_addr/link_data) are already updated while in WB.
module pc_sequencer #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    input  logic [4:0]       psr,
    input  logic [WIDTH-1:0] rtarget_data,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] src2,
    output logic             jumpEN,
    output logic             branchEN,
    output logic             jalEN,
    input  logic [WIDTH-1:0] pc_alu_out,
    input  logic [WIDTH-1:0] rlink_in,
    output logic             link_we,
    output logic [3:0]       link_addr,
    output logic [WIDTH-1:0] link_data,
    output logic [1:0]       dbg_state
`ifdef PC_SEQ_BRANCH_STATS_EN
    ,
    output logic [15:0]      taken_count,
    output logic [15:0]      nottaken_count
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [15:0]      ir_q;
    logic             branch_q;
    logic             jump_q;
    logic             jal_q;
    logic [WIDTH-1:0] src2_q;
    logic             link_we_q;
    logic [3:0]       link_addr_q;
    logic [WIDTH-1:0] link_data_q;

    // Decode of the instruction register (meaningful while in DECODE).
    logic             is_bcond;
    logic             is_jcond;
    logic             is_jal;
    logic             cond_true;
    logic             branch_d;
    logic             jump_d;
    logic             jal_d;
    logic [WIDTH-1:0] src2_d;

    // PSR flag fields, {C,L,F,Z,N} from bit 4 down to bit 0.
    logic flag_c;
    logic flag_l;
    logic flag_f;
    logic flag_z;
    logic flag_n;

    assign flag_c = psr[4];
    assign flag_l = psr[3];
    assign flag_f = psr[2];
    assign flag_z = psr[1];
    assign flag_n = psr[0];

    assign is_bcond = (ir_q[15:12] == 4'b1100);
    assign is_jcond = (ir_q[15:12] == 4'b0100) && (ir_q[7:4] == 4'b1100);
    assign is_jal   = (ir_q[15:12] == 4'b0100) && (ir_q[7:4] == 4'b1000);

    // Evaluate the condition field IR[11:8] against the live PSR flags.
    always_comb begin
        cond_true = 1'b0;
        case (ir_q[11:8])
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = ~flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = ~flag_c;
            4'b0100: cond_true = flag_l;
            4'b0101: cond_true = ~flag_l;
            4'b0110: cond_true = flag_n;
            4'b0111: cond_true = ~flag_n;
            4'b1000: cond_true = flag_f;
            4'b1001: cond_true = ~flag_f;
            4'b1010: cond_true = ~flag_l & ~flag_z;
            4'b1011: cond_true = flag_l | flag_z;
            4'b1100: cond_true = ~flag_n & ~flag_z;
            4'b1101: cond_true = flag_n | flag_z;
            4'b1110: cond_true = 1'b1;
            4'b1111: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    // Next values for the EXEC-cycle enables and the PC ALU operand.
    always_comb begin
        branch_d = is_bcond & cond_true;
        jump_d   = is_jcond & cond_true;
        jal_d    = is_jal;
        src2_d   = is_bcond ? {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]} : rtarget_data;
    end

`ifdef PC_SEQ_BRANCH_STATS_EN
    logic        cond_flow_q;
    logic [15:0] taken_cnt_q;
    logic [15:0] nottaken_cnt_q;

    assign taken_count    = taken_cnt_q;
    assign nottaken_count = nottaken_cnt_q;
`endif

    // Control-flow FSM with all registered outputs; reset wins over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            jal_q       <= 1'b0;
            src2_q      <= '0;
            link_we_q   <= 1'b0;
            link_addr_q <= '0;
            link_data_q <= '0;
`ifdef PC_SEQ_BRANCH_STATS_EN
            cond_flow_q    <= 1'b0;
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
`endif
        end else if (!stall) begin
            case (state_q)
                ST_FETCH: begin
                    if (instr_valid) begin
                        ir_q    <= instr;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // psr and rtarget_data are only sampled here.
                    branch_q <= branch_d;
                    jump_q   <= jump_d;
                    jal_q    <= jal_d;
                    src2_q   <= src2_d;
`ifdef PC_SEQ_BRANCH_STATS_EN
                    cond_flow_q <= is_bcond | is_jcond;
`endif
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    // The ALU returns pc+1 when no enable is raised.
                    branch_q <= 1'b0;
                    jump_q   <= 1'b0;
                    jal_q    <= 1'b0;
                    pc_q     <= pc_alu_out;
                    if (jal_q) begin
                        link_we_q   <= 1'b1;
                        link_addr_q <= ir_q[11:8];
                        link_data_q <= rlink_in;
                    end
`ifdef PC_SEQ_BRANCH_STATS_EN
                    if ((branch_q | jump_q | jal_q) && (taken_cnt_q != 16'hFFFF)) begin
                        taken_cnt_q <= taken_cnt_q + 16'd1;
                    end
                    if (cond_flow_q && !(branch_q | jump_q) && (nottaken_cnt_q != 16'hFFFF)) begin
                        nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
                    end
`endif
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    link_we_q <= 1'b0;
                    state_q   <= ST_FETCH;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign src2      = src2_q;
    assign branchEN  = branch_q;
    assign jumpEN    = jump_q;
    assign jalEN     = jal_q;
    assign link_we   = link_we_q;
    assign link_addr = link_addr_q;
    assign link_data = link_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios from the test plan followed by
// randomized instruction streams checked against a behavioural model of the
// instruction set (condition table, displacement arithmetic, PC update).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic [4:0]  psr;
    logic [15:0] rtarget_data;
    logic [15:0] pc;
    logic [15:0] src2;
    logic        jumpEN;
    logic        branchEN;
    logic        jalEN;
    logic [15:0] pc_alu_out;
    logic [15:0] rlink_in;
    logic        link_we;
    logic [3:0]  link_addr;
    logic [15:0] link_data;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int link_cycles = 0;
    int jump_cycles = 0;
    int multi_en = 0;
    logic [15:0] model_pc;
    logic [15:0] exp_q[$];

    typedef struct packed {
        logic [15:0] addr;
        logic        wait_ok;
        logic [2:0]  en;
        logic [15:0] src2;
        logic [2:0]  en_wb;
        logic [15:0] pc;
        logic        lwe;
        logic [3:0]  laddr;
        logic [15:0] ldata;
        logic        req_after;
    } obs_t;

    // Clock
    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .psr          (psr),
        .rtarget_data (rtarget_data),
        .pc           (pc),
        .src2         (src2),
        .jumpEN       (jumpEN),
        .branchEN     (branchEN),
        .jalEN        (jalEN),
        .pc_alu_out   (pc_alu_out),
        .rlink_in     (rlink_in),
        .link_we      (link_we),
        .link_addr    (link_addr),
        .link_data    (link_data),
        .dbg_state    (dbg_state)
    );

    // External PC ALU: branch adds src2, jump/JAL load src2, otherwise pc+1.
    always_comb begin
        if (branchEN)               pc_alu_out = pc + src2;
        else if (jumpEN || jalEN)   pc_alu_out = src2;
        else                        pc_alu_out = pc + 16'd1;
        rlink_in = pc + 16'd1;
    end

    // Cycle monitors for pulse widths and enable exclusivity.
    always @(negedge clk) begin
        if (link_we === 1'b1) link_cycles++;
        if (jumpEN === 1'b1) jump_cycles++;
        if ((int'(branchEN) + int'(jumpEN) + int'(jalEN)) > 1) multi_en++;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Returns {branch, jump, jal} expected in EXEC.
    function automatic logic [2:0] model_en(input logic [15:0] ins, input logic [4:0] flags);
        logic c, l, f, z, n;
        logic [7:0] preds;
        logic take;
        {c, l, f, z, n} = flags;
        // Conditions come in pairs; odd codes are the complement of even ones.
        preds = {1'b1, ~n & ~z, ~l & ~z, f, n, l, c, z};
        take = preds[ins[11:9]] ^ ins[8];
        if (ins[15:12] == 4'hC) return take ? 3'b100 : 3'b000;
        if (ins[15:12] == 4'h4 && ins[7:4] == 4'hC) return take ? 3'b010 : 3'b000;
        if (ins[15:12] == 4'h4 && ins[7:4] == 4'h8) return 3'b001;
        return 3'b000;
    endfunction

    function automatic int model_disp(input logic [15:0] ins);
        int d;
        d = int'(ins[7:0]);
        if (ins[7]) d = d - 256;
        return d;
    endfunction

    function automatic logic [15:0] model_next_pc(input logic [2:0] en, input logic [15:0] ins,
                                                 input logic [15:0] cur, input logic [15:0] rt);
        if (en == 3'b100) return 16'(int'(cur) + model_disp(ins));
        if (en != 3'b000) return rt;
        return 16'(int'(cur) + 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH and records what the DUT shows.
    task automatic drive_instr(input logic [15:0] ins, input logic [4:0] flags,
                               input logic [15:0] rt, input int wait_n, output obs_t o);
        logic [15:0] pc0;
        o = '0;
        o.addr = imem_addr;
        pc0 = imem_addr;
        o.wait_ok = 1'b1;
        instr_valid = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            instr = 16'($urandom);
            psr = 5'($urandom);
            step();
            if (imem_req !== 1'b1 || pc !== pc0) o.wait_ok = 1'b0;
        end
        instr = ins;
        instr_valid = 1'b1;
        psr = flags;
        rtarget_data = rt;
        step();                 // DECODE
        instr_valid = 1'b0;
        instr = 16'($urandom);
        step();                 // EXEC
        psr = 5'($urandom);     // must have no effect any more
        o.en = {branchEN, jumpEN, jalEN};
        o.src2 = src2;
        step();                 // WB
        o.en_wb = {branchEN, jumpEN, jalEN};
        o.pc = pc;
        o.lwe = link_we;
        o.laddr = link_addr;
        o.ldata = link_data;
        step();                 // FETCH
        o.req_after = imem_req;
    endtask

    // Moves the PC to a chosen value with an unconditional register jump.
    task automatic set_pc(input logic [15:0] target);
        obs_t o;
        drive_instr(16'h4EC0, 5'($urandom), target, 0, o);
        model_pc = target;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0000;
        psr = 5'h00;
        rtarget_data = 16'h0000;
        step();
        step();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_imem_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0000", imem_addr); end
        checks++; if ({branchEN, jumpEN, jalEN, link_we} !== 4'b0000) begin errors++; $display("FAIL reset_enables: got %b expected 0000", {branchEN, jumpEN, jalEN, link_we}); end
        checks++; if ({link_addr, link_data} !== 20'h0) begin errors++; $display("FAIL reset_link: got %h/%h expected 0/0000", link_addr, link_data); end
        reset = 1'b0;
        model_pc = 16'h0000;
    endtask

    task automatic test_nonflow();
        obs_t o;
        int lc0;
        lc0 = link_cycles;
        drive_instr(16'h0000, 5'($urandom), 16'($urandom), 0, o);
        checks++; if (o.addr !== 16'h0000) begin errors++; $display("FAIL nonflow_addr: got %h expected 0000", o.addr); end
        checks++; if (o.en !== 3'b000) begin errors++; $display("FAIL nonflow_en: got %b expected 000", o.en); end
        checks++; if (o.pc !== 16'h0001) begin errors++; $display("FAIL nonflow_pc: got %h expected 0001", o.pc); end
        checks++; if (o.req_after !== 1'b1) begin errors++; $display("FAIL nonflow_refetch: got %b expected 1", o.req_after); end
        checks++; if (link_cycles !== lc0) begin errors++; $display("FAIL nonflow_link_we: got %0d cycles expected %0d", link_cycles, lc0); end
        model_pc = 16'h0001;
    endtask

    task automatic test_bcond();
        obs_t o;
        set_pc(16'h0010);
        drive_instr(16'hC0F0, 5'b00010, 16'($urandom), 0, o);
        checks++; if (o.en !== 3'b100) begin errors++; $display("FAIL bcond_taken_en: got %b expected 100", o.en); end
        checks++; if (o.src2 !== 16'hFFF0) begin errors++; $display("FAIL bcond_src2: got %h expected FFF0", o.src2); end
        checks++; if (o.pc !== 16'h0000) begin errors++; $display("FAIL bcond_taken_pc: got %h expected 0000", o.pc); end
        checks++; if (o.en_wb !== 3'b000) begin errors++; $display("FAIL bcond_en_in_wb: got %b expected 000", o.en_wb); end
        set_pc(16'h0010);
        drive_instr(16'hC0F0, 5'b11101, 16'($urandom), 0, o);
        checks++; if (o.en !== 3'b000) begin errors++; $display("FAIL bcond_nottaken_en: got %b expected 000", o.en); end
        checks++; if (o.pc !== 16'h0011) begin errors++; $display("FAIL bcond_nottaken_pc: got %h expected 0011", o.pc); end
        drive_instr(16'hCF5A, 5'b11111, 16'($urandom), 0, o);
        checks++; if (o.en !== 3'b000) begin errors++; $display("FAIL bcond_never_en: got %b expected 000", o.en); end
        checks++; if (o.pc !== 16'h0012) begin errors++; $display("FAIL bcond_never_pc: got %h expected 0012", o.pc); end
        model_pc = 16'h0012;
    endtask

    task automatic test_jal();
        obs_t o;
        int lc0;
        set_pc(16'h0020);
        lc0 = link_cycles;
        drive_instr(16'h4E83, 5'($urandom), 16'h0100, 0, o);
        checks++; if (o.en !== 3'b001) begin errors++; $display("FAIL jal_en: got %b expected 001", o.en); end
        checks++; if (o.src2 !== 16'h0100) begin errors++; $display("FAIL jal_src2: got %h expected 0100", o.src2); end
        checks++; if (o.pc !== 16'h0100) begin errors++; $display("FAIL jal_pc: got %h expected 0100", o.pc); end
        checks++; if (o.lwe !== 1'b1) begin errors++; $display("FAIL jal_link_we: got %b expected 1", o.lwe); end
        checks++; if (o.laddr !== 4'hE) begin errors++; $display("FAIL jal_link_addr: got %h expected E", o.laddr); end
        checks++; if (o.ldata !== 16'h0021) begin errors++; $display("FAIL jal_link_data: got %h expected 0021", o.ldata); end
        checks++; if (link_cycles - lc0 !== 1) begin errors++; $display("FAIL jal_link_pulse: got %0d cycles expected 1", link_cycles - lc0); end
        model_pc = 16'h0100;
    endtask

    task automatic test_stall_jcond();
        logic [15:0] rt;
        logic ok;
        int jc0;
        rt = 16'($urandom);
        jc0 = jump_cycles;
        instr = 16'h4EC0;
        instr_valid = 1'b1;
        psr = 5'($urandom);
        rtarget_data = rt;
        step();                 // cycle 1: DECODE
        instr_valid = 1'b0;
        step();                 // cycle 2: EXEC
        checks++; if ({branchEN, jumpEN, jalEN} !== 3'b010) begin errors++; $display("FAIL stall_exec_en: got %b expected 010", {branchEN, jumpEN, jalEN}); end
        stall = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            psr = 5'($urandom);
            step();             // cycles 3..5: frozen in EXEC
            if (jumpEN !== 1'b1 || pc !== model_pc || imem_req !== 1'b0) ok = 1'b0;
        end
        stall = 1'b0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b expected 1", ok); end
        step();                 // cycle 6: WB
        checks++; if (pc !== rt) begin errors++; $display("FAIL stall_pc: got %h expected %h", pc, rt); end
        checks++; if ({jumpEN, imem_req} !== 2'b00) begin errors++; $display("FAIL stall_wb: got %b expected 00", {jumpEN, imem_req}); end
        step();                 // cycle 7: FETCH
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_total_cycles: got req %b expected 1", imem_req); end
        checks++; if (jump_cycles - jc0 !== 4) begin errors++; $display("FAIL stall_jump_width: got %0d cycles expected 4", jump_cycles - jc0); end
        model_pc = rt;
    endtask

    task automatic test_reset_mid();
        int lc0;
        lc0 = link_cycles;
        instr = 16'h4E83;
        instr_valid = 1'b1;
        psr = 5'($urandom);
        rtarget_data = 16'h0777;
        step();                 // DECODE
        instr_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({imem_req, pc} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL rst_decode: got req %b pc %h expected 1 0000", imem_req, pc); end
        step();                 // no instr_valid: stays in FETCH
        checks++; if ({imem_req, branchEN, jumpEN, jalEN} !== 4'b1000) begin errors++; $display("FAIL rst_idle: got %b expected 1000", {imem_req, branchEN, jumpEN, jalEN}); end
        set_pc(16'h0300);
        instr = 16'h4E83;
        instr_valid = 1'b1;
        step();                 // DECODE
        instr_valid = 1'b0;
        step();                 // EXEC
        checks++; if (jalEN !== 1'b1) begin errors++; $display("FAIL rst_exec_jal: got %b expected 1", jalEN); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({link_we, jalEN, pc} !== {2'b00, 16'h0000}) begin errors++; $display("FAIL rst_exec_drop: got we %b jal %b pc %h expected 0 0 0000", link_we, jalEN, pc); end
        step();
        checks++; if (link_cycles !== lc0) begin errors++; $display("FAIL rst_link_dropped: got %0d cycles expected %0d", link_cycles, lc0); end
        model_pc = 16'h0000;
    endtask

    task automatic test_wrap_wait();
        obs_t o;
        set_pc(16'hFFFF);
        drive_instr(16'h1234, 5'($urandom), 16'($urandom), 5, o);
        checks++; if (o.addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr: got %h expected FFFF", o.addr); end
        checks++; if (o.wait_ok !== 1'b1) begin errors++; $display("FAIL wait_hold: got %b expected 1", o.wait_ok); end
        checks++; if (o.pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h expected 0000", o.pc); end
        model_pc = 16'h0000;
    endtask

    task automatic test_random();
        obs_t o;
        logic [15:0] ins, rt, exp_pc;
        logic [4:0] flags;
        logic [2:0] exp_en;
        int lc0, jal_n, kind, w;
        lc0 = link_cycles;
        jal_n = 0;
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 3);
            ins = 16'($urandom);
            case (kind)
                0: ins[15:12] = 4'hC;
                1: begin ins[15:12] = 4'h4; ins[7:4] = 4'hC; end
                2: begin ins[15:12] = 4'h4; ins[7:4] = 4'h8; end
                default: ;
            endcase
            flags = 5'($urandom);
            rt = 16'($urandom);
            w = $urandom_range(0, 2);
            exp_en = model_en(ins, flags);
            exp_q.push_back(model_next_pc(exp_en, ins, model_pc, rt));
            drive_instr(ins, flags, rt, w, o);
            exp_pc = exp_q.pop_front();
            checks++; if (o.addr !== model_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", k, o.addr, model_pc); end
            checks++; if (o.en !== exp_en) begin errors++; $display("FAIL rnd_en[%0d] ins %h psr %b: got %b expected %b", k, ins, flags, o.en, exp_en); end
            checks++; if (o.pc !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d] ins %h: got %h expected %h", k, ins, o.pc, exp_pc); end
            checks++; if (o.en_wb !== 3'b000) begin errors++; $display("FAIL rnd_en_wb[%0d]: got %b expected 000", k, o.en_wb); end
            checks++; if (o.lwe !== (exp_en == 3'b001)) begin errors++; $display("FAIL rnd_link_we[%0d]: got %b expected %b", k, o.lwe, exp_en == 3'b001); end
            if (ins[15:12] == 4'hC) begin
                checks++; if (o.src2 !== 16'(model_disp(ins))) begin errors++; $display("FAIL rnd_src2_disp[%0d]: got %h expected %h", k, o.src2, 16'(model_disp(ins))); end
            end
            if (exp_en == 3'b001) begin
                jal_n++;
                checks++; if ({o.laddr, o.ldata} !== {ins[11:8], 16'(model_pc + 16'd1)}) begin errors++; $display("FAIL rnd_link[%0d]: got %h/%h expected %h/%h", k, o.laddr, o.ldata, ins[11:8], 16'(model_pc + 16'd1)); end
            end
            if (exp_en == 3'b010 || exp_en == 3'b001) begin
                checks++; if (o.src2 !== rt) begin errors++; $display("FAIL rnd_src2_reg[%0d]: got %h expected %h", k, o.src2, rt); end
            end
            model_pc = exp_pc;
        end
        checks++; if (link_cycles - lc0 !== jal_n) begin errors++; $display("FAIL rnd_link_count: got %0d expected %0d", link_cycles - lc0, jal_n); end
        checks++; if (multi_en !== 0) begin errors++; $display("FAIL one_hot_enables: got %0d overlaps expected 0", multi_en); end
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_nonflow();
        test_bcond();
        test_jal();
        test_stall_jcond();
        test_reset_mid();
        test_wrap_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
